fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC, issues requests to instruction memory, and drives the IF/ID pipeline buffer.

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage_pc_next_sel.sv | 33 +++
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encodings,
// the NOP word inserted on a flush, and the default sequential PC step.
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } fetchState_t;

   localparam logic [31:0] NOP_WORD        = 32'h0000_0000;
   localparam int          PC_STEP_DEFAULT = 4;

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// Redirect selection for the fetch stage: merges branch and jump requests.
// Jumps only take part when FETCH_JUMP_EN is defined; a branch always wins.
module fetch_stage_pc_next_sel
   import fetch_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              branchTaken_i,
   input  logic [DATA_W-1:0] branchTarget_i,
   input  logic              jump_i,
   input  logic [DATA_W-1:0] jumpTarget_i,
   output logic              redirect_o,
   output logic [DATA_W-1:0] target_o
);

`ifdef FETCH_JUMP_EN
   always_comb begin
      redirect_o = branchTaken_i | jump_i;
      target_o   = branchTaken_i ? branchTarget_i : jumpTarget_i;
   end
`else
   // Jump ports stay on the interface so the ID stage wiring never changes.
   logic unusedJump;

   always_comb begin
      redirect_o = branchTaken_i;
      target_o   = branchTarget_i;
   end

   assign unusedJump = ^{jump_i, jumpTarget_i};
`endif

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency imem and
// feeds the IF/ID buffer. Jump redirects are enabled by FETCH_JUMP_EN.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [DATA_W-1:0] branch_target,
   input  logic              jump,
   input  logic [DATA_W-1:0] jump_target,
   output logic              imem_req,
   output logic [DATA_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] pc_plus4,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid
);

   fetchState_t       state_q;
   logic [DATA_W-1:0] pc_q;
   logic [DATA_W-1:0] pcPlus4_q;
   logic [DATA_W-1:0] instr_q;
   logic              instrValid_q;
   logic [DATA_W-1:0] skidInstr_q;
   logic [DATA_W-1:0] skidP4_q;
   logic [DATA_W-1:0] savedTarget_q;

   logic              redirect;
   logic [DATA_W-1:0] target;
   logic [DATA_W-1:0] pcIncr_d;

   fetch_stage_pc_next_sel #(
      .DATA_W(DATA_W)
   ) u_pcNextSel (
      .branchTaken_i (branch_taken),
      .branchTarget_i(branch_target),
      .jump_i        (jump),
      .jumpTarget_i  (jump_target),
      .redirect_o    (redirect),
      .target_o      (target)
   );

   assign pcIncr_d = pc_q + DATA_W'(PC_STEP);

   // A redirect always flushes the delivered slot, even while ID stalls;
   // a request already on the bus is allowed to finish in DROP before the
   // PC moves, so imem_addr never changes under an outstanding request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         pcPlus4_q     <= '0;
         instr_q       <= DATA_W'(NOP_WORD);
         instrValid_q  <= 1'b0;
         skidInstr_q   <= '0;
         skidP4_q      <= '0;
         savedTarget_q <= '0;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (imem_ready) begin
                  if (redirect) begin
                     pc_q         <= target;
                     instr_q      <= DATA_W'(NOP_WORD);
                     instrValid_q <= 1'b0;
                  end else if (stall) begin
                     skidInstr_q <= imem_rdata;
                     skidP4_q    <= pcIncr_d;
                     state_q     <= HOLD;
                  end else begin
                     instr_q      <= imem_rdata;
                     pcPlus4_q    <= pcIncr_d;
                     instrValid_q <= 1'b1;
                     pc_q         <= pcIncr_d;
                  end
               end else if (redirect) begin
                  savedTarget_q <= target;
                  instr_q       <= DATA_W'(NOP_WORD);
                  instrValid_q  <= 1'b0;
                  state_q       <= DROP;
               end else if (!stall) begin
                  instrValid_q <= 1'b0;
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc_q         <= target;
                  instr_q      <= DATA_W'(NOP_WORD);
                  instrValid_q <= 1'b0;
                  state_q      <= FETCH;
               end else if (!stall) begin
                  instr_q      <= skidInstr_q;
                  pcPlus4_q    <= skidP4_q;
                  instrValid_q <= 1'b1;
                  pc_q         <= pcIncr_d;
                  state_q      <= FETCH;
               end
            end
            DROP: begin
               instrValid_q <= 1'b0;
               if (redirect) begin
                  savedTarget_q <= target;
                  instr_q       <= DATA_W'(NOP_WORD);
               end
               if (imem_ready) begin
                  pc_q    <= redirect ? target : savedTarget_q;
                  state_q <= FETCH;
               end
            end
            default: state_q <= FETCH;
         endcase
      end
   end

   assign imem_req    = !rst && (state_q != HOLD);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign pc_plus4    = pcPlus4_q;
   assign instr       = instr_q;
   assign instr_valid = instrValid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: table of per-cycle vectors plus a random-ready
// streaming sequence; delivered (pc_plus4, instr) pairs go through a queue.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] instr;
   logic        instr_valid;

   typedef struct {
      logic        rst;
      logic        ready;
      logic        stall;
      logic        br;
      logic [31:0] brt;
      logic        jmp;
      logic [31:0] jt;
      logic        expReq;
      logic [31:0] expAddr;
      logic        expValid;
      logic [31:0] expPc;
      logic        push;
      logic        pop;
      logic        chkNop;
      logic        frozen;
   } vec_t;

   typedef struct {
      logic [31:0] p4;
      logic [31:0] instr;
   } del_t;

   vec_t        vecs[$];
   del_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] curP4 = '0;
   logic [31:0] curInstr = '0;

   fetch_stage dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .jump         (jump),
      .jump_target  (jump_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .instr        (instr),
      .instr_valid  (instr_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic addVec(input logic r, input logic rdy, input logic st, input logic br,
                         input logic [31:0] brt, input logic j, input logic [31:0] jt,
                         input logic eReq, input logic [31:0] eAddr, input logic eVal,
                         input logic [31:0] ePc, input logic psh, input logic pp,
                         input logic nop, input logic frz);
      vec_t v;
      v.rst = r;  v.ready = rdy;  v.stall = st;  v.br = br;  v.brt = brt;
      v.jmp = j;  v.jt = jt;  v.expReq = eReq;  v.expAddr = eAddr;
      v.expValid = eVal;  v.expPc = ePc;  v.push = psh;  v.pop = pp;
      v.chkNop = nop;  v.frozen = frz;
      vecs.push_back(v);
   endtask

   // Drive one cycle, check the combinational request side, then clock it.
   task automatic applyStimulus(input vec_t v, input int i);
      del_t d;
      rst           = v.rst;
      imem_ready    = v.ready;
      stall         = v.stall;
      branch_taken  = v.br;
      branch_target = v.brt;
      jump          = v.jmp;
      jump_target   = v.jt;
      #1;
      imem_rdata = v.ready ? memWord(imem_addr) : 32'hBAD0_BAD0;
      #1;
      checkOutput($sformatf("row%0d imem_req", i), {31'b0, imem_req}, {31'b0, v.expReq});
      if (v.expReq)
         checkOutput($sformatf("row%0d imem_addr", i), imem_addr, v.expAddr);
      if (v.push) begin
         d.p4    = v.expAddr + 32'd4;
         d.instr = memWord(v.expAddr);
         sb.push_back(d);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic checkAfter(input vec_t v, input int i);
      del_t d;
      checkOutput($sformatf("row%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, v.expValid});
      checkOutput($sformatf("row%0d pc", i), pc, v.expPc);
      if (v.pop) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL row%0d scoreboard: got delivery, want empty queue", i);
         end else begin
            d = sb.pop_front();
            checkOutput($sformatf("row%0d pc_plus4", i), pc_plus4, d.p4);
            checkOutput($sformatf("row%0d instr", i), instr, d.instr);
            curP4    = d.p4;
            curInstr = d.instr;
         end
      end
      if (v.chkNop)
         checkOutput($sformatf("row%0d instr nop", i), instr, 32'h0);
      if (v.rst) begin
         checkOutput($sformatf("row%0d pc_plus4 reset", i), pc_plus4, 32'h0);
         curP4    = '0;
         curInstr = '0;
      end
      if (v.frozen) begin
         checkOutput($sformatf("row%0d pc_plus4 held", i), pc_plus4, curP4);
         checkOutput($sformatf("row%0d instr held", i), instr, curInstr);
      end
   endtask

   initial begin
      logic [31:0] jAddr;
      logic [31:0] expPc;
      vec_t        v;
      logic        rdy;

      // rst rdy st br brt jmp jt | eReq eAddr eVal ePc psh pop nop frz
      addVec(1,0,0,0,0,0,0,            0,0,0,0,                 0,0,1,0);
      addVec(0,1,0,0,0,0,0,            1,0,1,4,                 1,1,0,0);
      addVec(0,1,0,0,0,0,0,            1,4,1,8,                 1,1,0,0);
      addVec(0,1,0,0,0,0,0,            1,8,1,12,                1,1,0,0);
      addVec(1,0,0,0,0,0,0,            0,0,0,0,                 0,0,1,0);
      addVec(0,1,0,0,0,0,0,            1,0,1,4,                 1,1,0,0);
      addVec(0,1,0,0,0,0,0,            1,4,1,8,                 1,1,0,0);
      addVec(0,0,0,0,0,0,0,            1,8,0,8,                 0,0,0,0);
      addVec(0,0,0,0,0,0,0,            1,8,0,8,                 0,0,0,0);
      addVec(0,0,0,0,0,0,0,            1,8,0,8,                 0,0,0,0);
      addVec(0,1,0,0,0,0,0,            1,8,1,12,                1,1,0,0);
      addVec(0,1,0,0,0,0,0,            1,12,1,16,               1,1,0,0);
      addVec(0,1,1,0,0,0,0,            1,16,1,16,               1,0,0,1);
      addVec(0,0,1,0,0,0,0,            0,16,1,16,               0,0,0,1);
      addVec(0,0,0,0,0,0,0,            0,16,1,'h14,             0,1,0,0);
      addVec(0,1,0,0,0,0,0,            1,'h14,1,'h18,           1,1,0,0);
      addVec(0,1,0,0,0,0,0,            1,'h18,1,'h1C,           1,1,0,0);
      addVec(0,1,0,0,0,0,0,            1,'h1C,1,'h20,           1,1,0,0);
      addVec(0,0,0,1,'h40,0,0,         1,'h20,0,'h20,           0,0,1,0);
      addVec(0,0,0,0,0,0,0,            1,'h20,0,'h20,           0,0,1,0);
      addVec(0,1,0,0,0,0,0,            1,'h20,0,'h40,           0,0,1,0);
      addVec(0,1,0,0,0,0,0,            1,'h40,1,'h44,           1,1,0,0);
      addVec(0,1,1,0,0,0,0,            1,'h44,1,'h44,           0,0,0,1);
      addVec(0,0,1,1,'h60,0,0,         0,'h44,0,'h60,           0,0,1,0);
      addVec(0,1,1,1,'h80,1,'hC0,      1,'h60,0,'h80,           0,0,1,0);
      addVec(0,0,0,1,'h100,0,0,        1,'h80,0,'h80,           0,0,1,0);
      addVec(0,0,0,1,'h200,0,0,        1,'h80,0,'h80,           0,0,1,0);
      addVec(0,1,0,0,0,0,0,            1,'h80,0,'h200,          0,0,1,0);
`ifdef FETCH_JUMP_EN
      addVec(0,1,0,0,0,1,'hC0,         1,'h200,0,'hC0,          0,0,1,0);
      jAddr = 32'hC0;
`else
      addVec(0,1,0,0,0,1,'hC0,         1,'h200,1,'h204,         1,1,0,0);
      jAddr = 32'h204;
`endif
      addVec(0,0,0,1,'h300,0,0,        1,jAddr,0,jAddr,         0,0,1,0);
      addVec(1,0,0,0,0,0,0,            0,0,0,0,                 0,0,1,0);
      addVec(0,1,0,0,0,0,0,            1,0,1,4,                 1,1,0,0);
      addVec(0,0,0,1,'hFFFF_FFFC,0,0,  1,4,0,4,                 0,0,1,0);
      addVec(0,1,0,0,0,0,0,            1,4,0,'hFFFF_FFFC,       0,0,1,0);
      addVec(0,1,0,0,0,0,0,            1,'hFFFF_FFFC,1,0,       1,1,0,0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i], i);
         checkAfter(vecs[i], i);
      end

      // Streaming with an irregular imem: every ready cycle is one delivery.
      v = '{rst:1, ready:0, stall:0, br:0, brt:0, jmp:0, jt:0, expReq:0, expAddr:0,
            expValid:0, expPc:0, push:0, pop:0, chkNop:1, frozen:0};
      applyStimulus(v, 100);
      checkAfter(v, 100);
      expPc = '0;
      for (int k = 0; k < 40; k++) begin
         rdy = 1'($urandom_range(0, 1));
         v = '{rst:0, ready:rdy, stall:0, br:0, brt:0, jmp:0, jt:0, expReq:1,
               expAddr:expPc, expValid:rdy, expPc:(rdy ? expPc + 32'd4 : expPc),
               push:rdy, pop:rdy, chkNop:0, frozen:0};
         applyStimulus(v, 101 + k);
         checkAfter(v, 101 + k);
         expPc = v.expPc;
      end

      checkOutput("scoreboard drained", 32'(sb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
